// File: rtl/text_scroll_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : text_scroll_arbiter                                              |
// | Brief   : Fixed-priority owner of the shared text scroller (call/UI/status)|
// |           with dwell and start-timeout. Optional call-alert preemption     |
// |           when TEXT_SCROLL_ARBITER_PREEMPT_EN is defined.                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module text_scroll_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int MIN_DWELL     = 16,
  parameter int START_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [ADDR_W-1:0] req_len0,
  input  logic [ADDR_W-1:0] req_len1,
  input  logic [ADDR_W-1:0] req_len2,
  output logic [2:0]        accept,
  output logic [2:0]        done,
  output logic              err,
  output logic              scroll_start,
  output logic [ADDR_W-1:0] scroll_addr,
  output logic [ADDR_W-1:0] scroll_len,
  input  logic              scroll_busy,
  input  logic              scroll_done,
  output logic              active,
  output logic [1:0]        active_id,
  output logic              scroll_abort
);

  localparam int                c_dw_w        = $clog2(MIN_DWELL + 1);
  localparam logic [c_dw_w-1:0] c_min_dwell   = c_dw_w'(MIN_DWELL);
  localparam logic [8:0]        c_timeout     = 9'(START_TIMEOUT);
  localparam logic [1:0]        c_idle_id     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_SHOW      = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_len;
  logic [1:0]          r_id;
  logic [7:0]          r_to;
  logic [c_dw_w-1:0]   r_dw;
  logic                r_done_flag;
  logic                r_err;

  logic                w_gnt_vld;
  logic [1:0]          w_gnt_id;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [ADDR_W-1:0]   w_gnt_len;
  logic                w_load;
  logic                w_dwell_met;
  logic                w_finish_ok;
  logic                w_to_expire;
  logic                w_preempt;
  logic [2:0]          w_accept;
  logic [2:0]          w_done;
  logic                w_err;
  logic                w_start;

  function automatic logic [2:0] f_onehot(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

  // Reset gates the grant so no accept escapes while the block is held in reset.
  always_comb begin
    w_gnt_vld  = reset_n & (req != 3'b000);
    w_gnt_id   = 2'd2;
    w_gnt_addr = req_addr2;
    w_gnt_len  = req_len2;
    if (req[0]) begin
      w_gnt_id   = 2'd0;
      w_gnt_addr = req_addr0;
      w_gnt_len  = req_len0;
    end else if (req[1]) begin
      w_gnt_id   = 2'd1;
      w_gnt_addr = req_addr1;
      w_gnt_len  = req_len1;
    end
  end

  assign w_dwell_met = (r_dw >= c_min_dwell);
  assign w_finish_ok = (r_done_flag | scroll_done) & w_dwell_met;
  assign w_to_expire = ({1'b0, r_to} + 9'd1) == c_timeout;

`ifdef TEXT_SCROLL_ARBITER_PREEMPT_EN
  // A finished message is closed normally rather than aborted.
  assign w_preempt = reset_n & (r_state == S_SHOW) & w_dwell_met & (r_id != 2'd0)
                   & req[0] & ~w_finish_ok;
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 3'b000;
    w_done      = 3'b000;
    w_err       = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_load      = 1'b1;
          w_accept    = f_onehot(w_gnt_id);
          w_state_nxt = (w_gnt_len == '0) ? S_FINISH : S_START;
        end
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (scroll_busy || scroll_done) begin
          w_state_nxt = S_SHOW;
        end else if (w_to_expire) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_SHOW: begin
        if (w_finish_ok) begin
          w_state_nxt = S_FINISH;
        end else if (w_preempt) begin
          w_load      = 1'b1;
          w_accept    = f_onehot(w_gnt_id);
          w_done      = f_onehot(r_id);
          w_state_nxt = (w_gnt_len == '0) ? S_FINISH : S_START;
        end
      end
      S_FINISH: begin
        w_done      = f_onehot(r_id);
        w_err       = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_id        <= c_idle_id;
      r_to        <= '0;
      r_dw        <= '0;
      r_done_flag <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_START: begin
          r_to <= '0;
          r_dw <= '0;
          if (scroll_done) r_done_flag <= 1'b1;
        end
        S_WAIT_BUSY: begin
          r_to <= r_to + 8'd1;
          if (scroll_done) r_done_flag <= 1'b1;
          if (w_to_expire && !scroll_busy && !scroll_done) r_err <= 1'b1;
        end
        S_SHOW: begin
          if (!w_dwell_met) r_dw <= r_dw + 1'b1;
          if (scroll_done) r_done_flag <= 1'b1;
        end
        S_FINISH: begin
          r_id        <= c_idle_id;
          r_done_flag <= 1'b0;
          r_err       <= 1'b0;
        end
        default: ;
      endcase
      // A new grant overrides any bookkeeping of the message it replaces.
      if (w_load) begin
        r_addr      <= w_gnt_addr;
        r_len       <= w_gnt_len;
        r_id        <= w_gnt_id;
        r_done_flag <= 1'b0;
        r_err       <= 1'b0;
      end
    end
  end

  assign accept       = w_accept;
  assign done         = w_done;
  assign err          = w_err;
  assign scroll_start = w_start;
  assign scroll_addr  = r_addr;
  assign scroll_len   = r_len;
  assign scroll_abort = w_preempt;
  assign active       = (r_state != S_IDLE);
  assign active_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_text_scroll_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_text_scroll_arbiter                                           |
// | Brief   : Directed self-checking bench for text_scroll_arbiter.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_text_scroll_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [10:0] req_addr0, req_addr1, req_addr2;
  logic [10:0] req_len0, req_len1, req_len2;
  logic [2:0]  accept, done;
  logic        err, scroll_start, scroll_busy, scroll_done, active, scroll_abort;
  logic [10:0] scroll_addr, scroll_len;
  logic [1:0]  active_id;

  int n_chk = 0;
  int n_err = 0;
  int hits;

  text_scroll_arbiter #(.ADDR_W(11), .MIN_DWELL(16), .START_TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_len0(req_len0), .req_len1(req_len1), .req_len2(req_len2),
    .accept(accept), .done(done), .err(err), .scroll_start(scroll_start),
    .scroll_addr(scroll_addr), .scroll_len(scroll_len),
    .scroll_busy(scroll_busy), .scroll_done(scroll_done),
    .active(active), .active_id(active_id), .scroll_abort(scroll_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = 3'b000; scroll_busy = 1'b0; scroll_done = 1'b0;
    req_addr0 = 11'h7AA; req_addr1 = 11'h000; req_addr2 = 11'h000;
    req_len0 = 11'd1; req_len1 = 11'd0; req_len2 = 11'd0;
    repeat (3) next_cyc();
    #1;
    chk("rst_ctrl", {accept, done, err, scroll_start, active, active_id, scroll_abort},
        {3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0});
    chk("rst_data", {scroll_addr, scroll_len}, 22'd0);
    reset_n = 1'b1;
    next_cyc();

    // Single request, UI source
    req = 3'b010; req_addr1 = 11'h120; req_len1 = 11'd26; #1;
    chk("t1_accept", accept, 3'b010);
    next_cyc(); req = 3'b000; req_addr1 = 11'h555; req_len1 = 11'd3; #1;
    chk("t1_start", {scroll_start, active, active_id}, {1'b1, 1'b1, 2'd1});
    chk("t1_addr", scroll_addr, 11'h120);
    chk("t1_len", scroll_len, 11'd26);
    hits = 0;
    for (int c = 2; c <= 40; c++) begin
      next_cyc(); scroll_busy = (c >= 3); scroll_done = (c == 40); #1;
      if (done != 3'b000 || scroll_start) hits++;
    end
    chk("t1_no_early_done", hits, 0);
    chk("t1_addr_hold", scroll_addr, 11'h120);
    next_cyc(); scroll_done = 1'b0; scroll_busy = 1'b0; #1;
    chk("t1_done", {done, err}, {3'b010, 1'b0});
    next_cyc(); #1;
    chk("t1_idle", {active, active_id, done}, {1'b0, 2'd3, 3'b000});

    // Priority UI over status, then status times out
    next_cyc();
    req = 3'b110; req_addr1 = 11'h100; req_len1 = 11'd5; req_addr2 = 11'h200; req_len2 = 11'd7; #1;
    chk("t2_accept_ui", accept, 3'b010);
    next_cyc(); req = 3'b100; #1;
    chk("t2_start_ui", {scroll_start, scroll_addr}, {1'b1, 11'h100});
    next_cyc(); scroll_done = 1'b1; #1;
    hits = 0;
    for (int c = 3; c <= 19; c++) begin
      next_cyc(); scroll_done = 1'b0; #1;
      if (done != 3'b000 || accept != 3'b000) hits++;
    end
    chk("t2_dwell_hold", hits, 0);
    next_cyc(); #1;
    chk("t2_done_ui_bubble", {done, accept}, {3'b010, 3'b000});
    next_cyc(); #1;
    chk("t2_accept_status", {accept, active, active_id}, {3'b100, 1'b0, 2'd3});
    next_cyc(); req = 3'b000; #1;
    chk("t2_start_status", {scroll_start, scroll_addr, scroll_len}, {1'b1, 11'h200, 11'd7});
    hits = 0;
    for (int c = 23; c <= 277; c++) begin
      next_cyc(); #1;
      if (done != 3'b000 || err) hits++;
    end
    chk("t3_no_early_timeout", hits, 0);
    next_cyc(); #1;
    chk("t3_timeout", {done, err, active_id}, {3'b100, 1'b1, 2'd2});
    next_cyc(); #1;
    chk("t3_after", {active, err, done}, {1'b0, 1'b0, 3'b000});

    // Early scroll_done deferred until dwell is met
    next_cyc(); req = 3'b001; req_addr0 = 11'h0AB; req_len0 = 11'd3; #1;
    chk("t4_accept", accept, 3'b001);
    next_cyc(); req = 3'b000; #1;
    chk("t4_start", {scroll_start, scroll_addr}, {1'b1, 11'h0AB});
    next_cyc(); scroll_busy = 1'b1; #1;
    next_cyc(); #1;
    next_cyc(); scroll_done = 1'b1; #1;
    hits = 0;
    for (int c = 5; c <= 19; c++) begin
      next_cyc(); scroll_done = 1'b0; #1;
      if (done != 3'b000) hits++;
    end
    chk("t4_no_early_done", hits, 0);
    next_cyc(); scroll_busy = 1'b0; #1;
    chk("t4_done", {done, err}, {3'b001, 1'b0});

    // Zero length skips the scroller
    next_cyc(); #1;
    next_cyc(); req = 3'b001; req_len0 = 11'd0; #1;
    chk("t5_accept", accept, 3'b001);
    next_cyc(); req = 3'b000; #1;
    chk("t5_done", {done, scroll_start, err}, {3'b001, 1'b0, 1'b0});
    next_cyc(); #1;
    chk("t5_idle", {active, active_id}, {1'b0, 2'd3});

    // Reset in the middle of SHOW
    next_cyc(); req = 3'b010; req_addr1 = 11'h333; req_len1 = 11'd9; #1;
    next_cyc(); req = 3'b000; #1;
    next_cyc(); scroll_busy = 1'b1; #1;
    repeat (3) next_cyc();
    #1;
    chk("t6_active", {active, active_id}, {1'b1, 2'd1});
    reset_n = 1'b0; #1;
    chk("t6_rst_ctrl", {accept, done, err, scroll_start, active, active_id, scroll_abort},
        {3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0});
    chk("t6_rst_data", {scroll_addr, scroll_len}, 22'd0);
    next_cyc(); scroll_busy = 1'b0; reset_n = 1'b1; #1;
    next_cyc(); #1;
    chk("t6_no_done", {done, active}, {3'b000, 1'b0});

`ifdef TEXT_SCROLL_ARBITER_PREEMPT_EN
    // Call alert preempts a status message after dwell
    next_cyc(); req = 3'b100; req_addr2 = 11'h210; req_len2 = 11'd4; #1;
    chk("t7_accept", accept, 3'b100);
    next_cyc(); req = 3'b000; #1;
    next_cyc(); scroll_busy = 1'b1; #1;
    for (int c = 3; c <= 18; c++) next_cyc();
    next_cyc(); req = 3'b001; req_addr0 = 11'h0C0; req_len0 = 11'd8; #1;
    chk("t7_abort", {scroll_abort, done, accept, err}, {1'b1, 3'b100, 3'b001, 1'b0});
    next_cyc(); req = 3'b000; scroll_busy = 1'b0; #1;
    chk("t7_restart", {scroll_start, scroll_addr, active_id, scroll_abort}, {1'b1, 11'h0C0, 2'd0, 1'b0});
`else
    chk("t7_abort_tied", {scroll_abort}, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_scroll_arbiter.md
Name: text_scroll_arbiter

Overview:
- Shares the single text scroller between three message sources: incoming-call alert, user-interface menu text, and system date/time/status text.
- Latches the winning request's ROM address and length, then issues the scroller start pulse.
- Tracks scroller busy/done and enforces a minimum on-screen dwell time.
- Returns per-requester accept/done/error pulses.

Parameters:
- ADDR_W, 11, width of text ROM address and length fields
- MIN_DWELL, 16, minimum cycles a message is owned after scroller start, before completion is reported
- START_TIMEOUT, 255, max cycles to wait for scroll_busy after start; 8-bit counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  3  request per source; bit0 = call alert (highest priority), bit1 = UI menu, bit2 = status (lowest)
- req_addr0, req_addr1, req_addr2  in  ADDR_W each  text start address per source
- req_len0, req_len1, req_len2  in  ADDR_W each  text length in characters per source
- accept  out  3  one-cycle pulse: the source's request has been latched
- done  out  3  one-cycle pulse: the source's message is finished
- err  out  1  one-cycle pulse together with done: scroller start timed out
- scroll_start  out  1  one-cycle start strobe to the scroller
- scroll_addr  out  ADDR_W  latched address; stable from start until done
- scroll_len  out  ADDR_W  latched length; stable from start until done
- scroll_busy  in  1  scroller is running
- scroll_done  in  1  one-cycle pulse: scroller has finished its message
- active  out  1  a message is owned
- active_id  out  2  owning source, 0..2; holds 3 when idle
- scroll_abort  out  1  preemption strobe (PREEMPT_EN only); tied 0 otherwise

Behaviour:
- Reset (async, reset_n=0): state=IDLE; every output 0 except active_id=3; counters 0.
- Reset asserted mid-message: no done pulse is generated; requesters must re-request.
- Handshake:
  - Source holds req high with stable addr/len until it sees its accept pulse.
  - req may drop any time after accept.
  - If req is still high at done+1, the source re-enters arbitration (repeat display).
- IDLE:
  - Grant the lowest set index of req (fixed priority).
  - In the same cycle: latch addr/len/id, pulse accept[id], set active=1.
  - Next state: START. If the latched len==0, go to FINISH instead (no scroller start).
- START: scroll_start=1 for exactly one cycle; clear dwell and timeout counters; next state WAIT_BUSY.
- Latency: req high in IDLE -> accept in that cycle -> scroll_start one cycle later.
- WAIT_BUSY:
  - scroll_busy=1 or scroll_done=1 -> SHOW. A done seen here is recorded as already-done.
  - Timeout counter reaching START_TIMEOUT -> set err flag, go to FINISH.
- SHOW:
  - Dwell counter increments every cycle and saturates at MIN_DWELL.
  - Leave for FINISH once the done flag is set (scroll_done seen) and dwell >= MIN_DWELL.
  - A scroll_done arriving before MIN_DWELL is remembered; completion is deferred until dwell is met.
- FINISH:
  - Pulse done[active_id]; pulse err if flagged.
  - Clear active; active_id=3; clear flags.
  - Next state IDLE. No grant is issued in the FINISH cycle, so there is one idle bubble between messages.
- Ignored inputs:
  - scroll_done or scroll_busy while in IDLE.
  - Changes to req addr/len after accept.
- Simultaneous requests: the highest priority wins; losers keep req high and are served later.
  - Fixed priority; starvation of low priority sources is allowed by design.

Optional Feature:
- Macro: TEXT_SCROLL_ARBITER_PREEMPT_EN.
- Defined:
  - In SHOW with dwell >= MIN_DWELL and active_id != 0, req[0]=1 causes: scroll_abort pulse for one cycle, done[active_id] pulse with err=0, then a direct jump to START with source 0 latched and accept[0] pulsed in the abort cycle.
  - No IDLE bubble.
  - The preempted source sees done and may re-request.
- Undefined: no preemption; scroll_abort is constant 0; call alerts wait for the current message to finish.

Test Plan:
- Single request: req=3'b010, addr1=0x120, len1=26, scroller busy at +2 and done at +40 -> accept[1] at cycle 0, scroll_start at cycle 1 with addr 0x120 and len 26, done[1] in the cycle after done is seen.
- Priority: req=3'b110 simultaneously -> UI (id1) served first; status (id2) accepted in the cycle after the FINISH bubble.
- Dwell: MIN_DWELL=16, scroll_done 3 cycles after start -> done pulse delayed until dwell reaches 16, not earlier.
- Timeout: scroll_busy held 0 -> err and done[id] asserted START_TIMEOUT+2 cycles after accept; active then 0.
- Zero length: len0=0 -> accept[0], no scroll_start, done[0] on the next cycle.
- Reset/preempt:
  - reset_n low mid-SHOW -> all outputs 0 and active_id=3 immediately.
  - With PREEMPT_EN, req[0] during an id2 message after dwell -> scroll_abort, done[2], then scroll_start with addr0.
